approx_mult_dot_accum: RTL and testbench

- Streaming dot-product controller built around the 8x8 unsigned approximate multiplier.
- Accepts operand pairs over a valid/ready handshake and registers them onto the multiplier inputs.
- Consumes the multiplier's 16-bit product one cycle later and accumulates N_TERMS products, or fewer on early termination.
- Presents the group sum downstream over a valid/ready handshake. The multiplier is instantiated externally and connected by the mul_* ports.

---
 rtl/approx_mult_dot_accum.sv | 126 ++++++++++++
 tb/tb_approx_mult_dot_accum.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_dot_accum.sv
// Streaming dot-product controller around an external 8x8 approximate
// multiplier. Operand pairs are registered onto mul_x/mul_y, the product
// returns combinationally on mul_z and is accumulated one edge later.
// A group closes after N_TERMS pairs or on in_last, and its saturating sum
// is offered downstream over a valid/ready handshake.
module approx_mult_dot_accum #(
  parameter int N_TERMS = 16,
  parameter int ACC_W   = 20,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  input  logic             in_last,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  input  logic [15:0]      mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_OUT} state_t;

  state_t             state_q, state_d;
  logic               vld_p1;
  logic [ACC_W-1:0]   acc_p1;
  logic               sat_p1;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, hs, last_term;
  logic [ACC_W:0]     acc_sum;

  // Unsigned add of a zero-extended product; MSB of the result flags overflow
  // and the value part is forced to all ones when it happens.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [15:0]      z);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - 16){1'b0}}, z};
    if (s[ACC_W])
      return {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign last_term = in_last | (cnt_q == CNT_W'(N_TERMS - 1));
  assign acc_sum   = sat_add(acc_p1, mul_z);

  // Next-state decode for the group sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:   if (accept && last_term) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT:   if (hs) state_d = ST_ACC;
      default:  state_d = ST_ACC;
    endcase
  end

  // State register; in_ready and out_valid are registered decodes of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_ACC);
      out_valid <= (state_d == ST_OUT);
    end
  end

  // Stage p0 -> p1: capture the accepted pair onto the multiplier inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_x  <= '0;
      mul_y  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        mul_x <= in_x;
        mul_y <= in_y;
      end
    end
  end

  // Stage p1 -> acc: fold in the product and count terms; cleared on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
      sat_p1 <= 1'b0;
      cnt_q  <= '0;
    end else if (hs) begin
      acc_p1 <= '0;
      sat_p1 <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (vld_p1) begin
        acc_p1 <= acc_sum[ACC_W-1:0];
        sat_p1 <= sat_p1 | acc_sum[ACC_W];
      end
      if (accept)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result capture at the DRAIN edge; held afterwards until the next group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (state_q == ST_DRAIN) begin
      out_sum   <= acc_sum[ACC_W-1:0];
      out_count <= cnt_q;
      out_sat   <= sat_p1 | acc_sum[ACC_W];
    end
  end

endmodule

// File: tb/tb_approx_mult_dot_accum.sv
// Directed bench for approx_mult_dot_accum. Two instances with N_TERMS=4
// share the stimulus: u_a with a 20-bit accumulator, u_b with a 16-bit one
// so that saturation can be reached.
module tb_approx_mult_dot_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        approx_mode = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_sat;
  logic [7:0]  a_mul_x, a_mul_y;
  logic [15:0] a_mul_z;
  logic [19:0] a_out_sum;
  logic [2:0]  a_out_count;

  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [7:0]  b_mul_x, b_mul_y;
  logic [15:0] b_mul_z;
  logic [15:0] b_out_sum;
  logic [2:0]  b_out_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] emul(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  // Approximate model: ignores the low bit of each operand.
  function automatic logic [15:0] amul(input logic [7:0] x, input logic [7:0] y);
    return 16'({x[7:1], 1'b0}) * 16'({y[7:1], 1'b0});
  endfunction

  function automatic logic [15:0] prod(input logic [7:0] x, input logic [7:0] y);
    return approx_mode ? amul(x, y) : emul(x, y);
  endfunction

  assign a_mul_z = prod(a_mul_x, a_mul_y);
  assign b_mul_z = prod(b_mul_x, b_mul_y);

  approx_mult_dot_accum #(.N_TERMS(4), .ACC_W(20)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .mul_x(a_mul_x), .mul_y(a_mul_y), .mul_z(a_mul_z),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_count(a_out_count), .out_sat(a_out_sat)
  );

  approx_mult_dot_accum #(.N_TERMS(4), .ACC_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_z(b_mul_z),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_sat(b_out_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair and return 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic last);
    int g = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_last = last;
    while (!a_in_ready && g < 50) begin tick(); g++; end
    if (g >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%0b want=1", a_in_ready);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int g = 0;
    while (!a_out_valid && g < 20) begin tick(); g++; end
    if (g >= 20) begin
      total++; bad++;
      $display("FAIL %s_timeout out_valid=%0b want=1", name, a_out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({a_in_ready, a_out_valid, a_mul_x, a_mul_y, a_out_sum, a_out_count, a_out_sat}
        !== {1'b1, 1'b0, 8'd0, 8'd0, 20'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals rdy=%0b vld=%0b mx=%0d my=%0d sum=%0d cnt=%0d sat=%0b want 1 0 0 0 0 0 0",
               a_in_ready, a_out_valid, a_mul_x, a_mul_y, a_out_sum, a_out_count, a_out_sat);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_rdy got=%0b want=1", a_in_ready);
    end
  endtask

  task automatic test_full_group();
    send(3, 5, 0); send(10, 10, 0); send(255, 1, 0); send(0, 200, 0);
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL full_latency_e0 out_valid=%0b want=0", a_out_valid);
    end
    tick();
    total++;
    if (a_out_valid !== 1'b1) begin
      bad++; $display("FAIL full_latency_e1 out_valid=%0b want=1", a_out_valid);
    end
    total++;
    if ({a_out_sum, a_out_count, a_out_sat} !== {20'd370, 3'd4, 1'b0}) begin
      bad++; $display("FAIL full_result sum=%0d cnt=%0d sat=%0b want 370 4 0",
                      a_out_sum, a_out_count, a_out_sat);
    end
    handshake();
    total++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      bad++; $display("FAIL full_after_hs vld=%0b rdy=%0b want 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_early_last();
    send(7, 9, 0); send(2, 2, 1);
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++; $display("FAIL early_rdy_drain got=%0b want=0", a_in_ready);
    end
    tick();
    total++;
    if ({a_out_valid, a_in_ready} !== 2'b10) begin
      bad++; $display("FAIL early_out_state vld=%0b rdy=%0b want 1 0", a_out_valid, a_in_ready);
    end
    total++;
    if ({a_out_sum, a_out_count} !== {20'd67, 3'd2}) begin
      bad++; $display("FAIL early_result sum=%0d cnt=%0d want 67 2", a_out_sum, a_out_count);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    send(6, 7, 1);
    wait_result("stall");
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({a_out_valid, a_in_ready, a_out_sum, a_out_count} !== {1'b1, 1'b0, 20'd42, 3'd1}) begin
        bad++; $display("FAIL stall_hold_%0d vld=%0b rdy=%0b sum=%0d cnt=%0d want 1 0 42 1",
                        i, a_out_valid, a_in_ready, a_out_sum, a_out_count);
      end
      tick();
    end
    handshake();
    send(1, 1, 1);
    wait_result("after_stall");
    total++;
    if ({a_out_sum, a_out_count} !== {20'd1, 3'd1}) begin
      bad++; $display("FAIL acc_cleared sum=%0d cnt=%0d want 1 1", a_out_sum, a_out_count);
    end
    handshake();
  endtask

  task automatic test_saturation();
    send(255, 255, 0); send(255, 255, 1);
    wait_result("sat");
    total++;
    if ({b_out_sum, b_out_sat} !== {16'd65535, 1'b1}) begin
      bad++; $display("FAIL sat16 sum=%0d sat=%0b want 65535 1", b_out_sum, b_out_sat);
    end
    total++;
    if ({a_out_sum, a_out_sat} !== {20'd130050, 1'b0}) begin
      bad++; $display("FAIL nosat20 sum=%0d sat=%0b want 130050 0", a_out_sum, a_out_sat);
    end
    handshake();
    send(2, 3, 1);
    wait_result("sat_clear");
    total++;
    if ({b_out_sum, b_out_sat} !== {16'd6, 1'b0}) begin
      bad++; $display("FAIL sat_cleared sum=%0d sat=%0b want 6 0", b_out_sum, b_out_sat);
    end
    handshake();
  endtask

  task automatic test_random_groups();
    approx_mode = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      int n, s, exp_b;
      logic [7:0] x, y;
      logic last;
      n = $urandom_range(1, 4);
      s = 0;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        last = (i == n - 1) ? ((n < 4) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        s += int'(amul(x, y));
        send(x, y, last);
      end
      wait_result("rand");
      repeat ($urandom_range(0, 2)) tick();
      exp_b = (s > 65535) ? 65535 : s;
      total++;
      if ({a_out_sum, a_out_count, a_out_sat} !== {20'(s), 3'(n), 1'b0}) begin
        bad++; $display("FAIL rand_a_g%0d sum=%0d cnt=%0d sat=%0b want %0d %0d 0",
                        g, a_out_sum, a_out_count, a_out_sat, s, n);
      end
      total++;
      if ({b_out_sum, b_out_count, b_out_sat} !== {16'(exp_b), 3'(n), (s > 65535)}) begin
        bad++; $display("FAIL rand_b_g%0d sum=%0d cnt=%0d sat=%0b want %0d %0d %0b",
                        g, b_out_sum, b_out_count, b_out_sat, exp_b, n, (s > 65535));
      end
      handshake();
    end
    approx_mode = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    send(9, 9, 1);
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_pre_drain rdy=%0b want=0", a_in_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_in_ready, a_out_valid, a_mul_x, a_mul_y, a_out_sum, a_out_count, a_out_sat}
        !== {1'b1, 1'b0, 8'd0, 8'd0, 20'd0, 3'd0, 1'b0}) begin
      bad++; $display("FAIL rst_drain_vals rdy=%0b vld=%0b mx=%0d sum=%0d cnt=%0d sat=%0b want 1 0 0 0 0 0",
                      a_in_ready, a_out_valid, a_mul_x, a_out_sum, a_out_count, a_out_sat);
    end
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      bad++; $display("FAIL rst_drain_release rdy=%0b vld=%0b want 1 0", a_in_ready, a_out_valid);
    end
    send(4, 4, 1);
    wait_result("rst_next");
    total++;
    if ({a_out_sum, a_out_count} !== {20'd16, 3'd1}) begin
      bad++; $display("FAIL rst_next_group sum=%0d cnt=%0d want 16 1", a_out_sum, a_out_count);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_early_last();
    test_backpressure();
    test_saturation();
    test_random_groups();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
